// File: rtl/mdu_ctrl.sv
// HI/LO multiply/divide sequencer: fixed-latency multiply, 32-step restoring divide, pipeline stall.
// Define MDU_MADD_EN to turn ops 110/111 into MADD/MADDU (accumulate into HI/LO); otherwise they are no-ops.
module mdu_ctrl #(
  parameter int MUL_LAT  = 5,
  parameter int DIV_ITER = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        rd_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef MDU_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MADDU = 3'b111;
`endif

  state_t      state_reg;
  logic [4:0]  cnt_reg;
  logic        busy_reg;
  logic        done_reg;
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;
  logic [63:0] prod_reg;
  logic        madd_reg;
  logic [31:0] dvnd_raw_reg;
  logic [31:0] dvsr_reg;
  logic [31:0] quo_reg;
  logic [31:0] rem_reg;
  logic        q_neg_reg;
  logic        r_neg_reg;

  logic        accept;
  logic        op_signed;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] product;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] rem_shift;
  logic [32:0] rem_sub;
  logic        step_ge;
  logic [31:0] q_fix;
  logic [31:0] r_fix;
  logic [63:0] mul_result;

  assign accept    = start_i & ~busy_reg & ~flush_i;
  // Bit 0 of every arithmetic opcode selects the unsigned variant.
  assign op_signed = ~op_i[0];

  assign mul_a   = {{32{op_signed & a_i[31]}}, a_i};
  assign mul_b   = {{32{op_signed & b_i[31]}}, b_i};
  assign product = mul_a * mul_b;

  assign abs_a = (op_signed & a_i[31]) ? (32'd0 - a_i) : a_i;
  assign abs_b = (op_signed & b_i[31]) ? (32'd0 - b_i) : b_i;

  // Partial remainder stays below the divisor, so bit 32 of the trial difference is a clean borrow.
  assign rem_shift = {rem_reg, quo_reg[31]};
  assign rem_sub   = rem_shift - {1'b0, dvsr_reg};
  assign step_ge   = ~rem_sub[32];

  assign q_fix = q_neg_reg ? (32'd0 - quo_reg) : quo_reg;
  assign r_fix = r_neg_reg ? (32'd0 - rem_reg) : rem_reg;

  assign mul_result = madd_reg ? ({hi_reg, lo_reg} + prod_reg) : prod_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      cnt_reg      <= 5'd0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      hi_reg       <= 32'd0;
      lo_reg       <= 32'd0;
      prod_reg     <= 64'd0;
      madd_reg     <= 1'b0;
      dvnd_raw_reg <= 32'd0;
      dvsr_reg     <= 32'd0;
      quo_reg      <= 32'd0;
      rem_reg      <= 32'd0;
      q_neg_reg    <= 1'b0;
      r_neg_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            case (op_i)
              OP_MULT, OP_MULTU: begin
                prod_reg  <= product;
                madd_reg  <= 1'b0;
                cnt_reg   <= 5'(MUL_LAT - 1);
                busy_reg  <= 1'b1;
                state_reg <= MUL;
              end
`ifdef MDU_MADD_EN
              OP_MADD, OP_MADDU: begin
                prod_reg  <= product;
                madd_reg  <= 1'b1;
                cnt_reg   <= 5'(MUL_LAT - 1);
                busy_reg  <= 1'b1;
                state_reg <= MUL;
              end
`endif
              OP_DIV, OP_DIVU: begin
                dvnd_raw_reg <= a_i;
                dvsr_reg     <= abs_b;
                quo_reg      <= abs_a;
                rem_reg      <= 32'd0;
                q_neg_reg    <= op_signed & (a_i[31] ^ b_i[31]);
                r_neg_reg    <= op_signed & a_i[31];
                cnt_reg      <= 5'(DIV_ITER - 1);
                busy_reg     <= 1'b1;
                state_reg    <= DIV;
              end
              OP_MTHI: hi_reg <= a_i;
              OP_MTLO: lo_reg <= a_i;
              default: ;
            endcase
          end
        end
        MUL: begin
          if (flush_i) begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else if (cnt_reg == 5'd0) begin
            {hi_reg, lo_reg} <= mul_result;
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg - 5'd1;
          end
        end
        DIV: begin
          if (flush_i) begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            // The dividend shifts out of quo_reg as quotient bits shift in.
            rem_reg <= step_ge ? rem_sub[31:0] : rem_shift[31:0];
            quo_reg <= {quo_reg[30:0], step_ge};
            if (cnt_reg == 5'd0) begin
              state_reg <= FIX;
            end else begin
              cnt_reg <= cnt_reg - 5'd1;
            end
          end
        end
        FIX: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
          if (!flush_i) begin
            done_reg <= 1'b1;
            if (dvsr_reg == 32'd0) begin
              hi_reg <= dvnd_raw_reg;
              lo_reg <= 32'hFFFF_FFFF;
            end else begin
              hi_reg <= r_fix;
              lo_reg <= q_fix;
            end
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy_o  = busy_reg;
  assign done_o  = done_reg;
  assign hi_o    = hi_reg;
  assign lo_o    = lo_reg;
  assign stall_o = busy_reg & (start_i | rd_i);

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed corner cases plus random ops against an arithmetic reference model.
module tb_mdu_ctrl;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        rd;
  logic        flush;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mdu_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .start_i(start),
    .op_i   (op),
    .a_i    (a),
    .b_i    (b),
    .rd_i   (rd),
    .flush_i(flush),
    .busy_o (busy),
    .stall_o(stall),
    .done_o (done),
    .hi_o   (hi),
    .lo_o   (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Architectural result of one op: returns the new {HI,LO}.
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x,
                                             input logic [31:0] y, input logic [31:0] h,
                                             input logic [31:0] l);
    int     sx;
    int     sy;
    longint px;
    sx = x;
    sy = y;
    case (o)
      3'd0: begin px = longint'(sx) * longint'(sy); return px; end
      3'd1: return {32'd0, x} * {32'd0, y};
      3'd2: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        return {32'(sx % sy), 32'(sx / sy)};
      end
      3'd3: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
      3'd4: return {x, l};
      3'd5: return {h, x};
`ifdef MDU_MADD_EN
      3'd6: begin px = longint'(sx) * longint'(sy); return {h, l} + px; end
      3'd7: return {h, l} + {32'd0, x} * {32'd0, y};
`endif
      default: return {h, l};
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] o);
    case (o)
      3'd0, 3'd1: return MUL_LAT;
      3'd2, 3'd3: return DIV_LAT;
`ifdef MDU_MADD_EN
      3'd6, 3'd7: return MUL_LAT;
`endif
      default: return 0;
    endcase
  endfunction

  // Issue one op, wait (bounded) for completion, compare against the model.
  task automatic exec(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    int cnt;
    logic [63:0] exp;
    int lat;
    exp = ref_result(o, x, y, m_hi, m_lo);
    lat = ref_lat(o);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h busy_cycles=%0d done=%b", o, x, y, hi, lo, cnt, done);
    check("busy_cycles", 64'(cnt), 64'(lat));
    check("hi", {32'd0, hi}, {32'd0, m_hi});
    check("lo", {32'd0, lo}, {32'd0, m_lo});
    check("done_pulse", {63'd0, done}, {63'd0, (lat > 0)});
    @(negedge clk);
    check("done_clear", {63'd0, done}, 64'd0);
  endtask

  initial begin
    int cnt;
    logic [63:0] r1;
    logic [63:0] r2;
    rst = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0; rd = 1'b0; flush = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);

    // Directed arithmetic cases
    exec(3'd0, 32'hFFFF_FFFE, 32'd3);
    exec(3'd2, 32'hFFFF_FFF9, 32'd2);
    exec(3'd3, 32'd7, 32'd2);
    exec(3'd3, 32'h1234_5678, 32'd0);
    exec(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    exec(3'd2, 32'h8765_4321, 32'd0);

    // MULTU with MFHI held: stall for exactly MUL_LAT cycles
    r1 = ref_result(3'd1, 32'hDEAD_BEEF, 32'h1000_0001, m_hi, m_lo);
    @(negedge clk);
    start = 1'b1; op = 3'd1; a = 32'hDEAD_BEEF; b = 32'h1000_0001;
    @(negedge clk);
    start = 1'b0; rd = 1'b1;
    cnt = 0;
    while (stall === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    m_hi = r1[63:32]; m_lo = r1[31:0];
    $display("rd_stall multu stall_cycles=%0d hi=%h lo=%h", cnt, hi, lo);
    check("rd_stall_cycles", 64'(cnt), 64'(MUL_LAT));
    check("rd_stall_hi", {32'd0, hi}, {32'd0, m_hi});
    check("rd_stall_lo", {32'd0, lo}, {32'd0, m_lo});
    rd = 1'b0;

    // Back-to-back MULTU: second held by stall, accepted as busy falls
    r1 = ref_result(3'd1, 32'h0001_0000, 32'h0003_0000, m_hi, m_lo);
    r2 = ref_result(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r1[63:32], r1[31:0]);
    @(negedge clk);
    start = 1'b1; op = 3'd1; a = 32'h0001_0000; b = 32'h0003_0000;
    @(negedge clk);
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    check("b2b_stall", {63'd0, stall}, 64'd1);
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    check("b2b_first_cycles", 64'(cnt), 64'(MUL_LAT));
    check("b2b_first_result", {hi, lo}, r1);
    check("b2b_stall_release", {63'd0, stall}, 64'd0);
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    m_hi = r2[63:32]; m_lo = r2[31:0];
    $display("b2b multu second busy_cycles=%0d hi=%h lo=%h", cnt, hi, lo);
    check("b2b_second_cycles", 64'(cnt), 64'(MUL_LAT));
    check("b2b_second_result", {hi, lo}, r2);

    // Flush mid-DIV leaves seeded HI/LO untouched
    exec(3'd4, 32'hAAAA_AAAA, 32'd0);
    exec(3'd5, 32'h5555_5555, 32'd0);
    @(negedge clk);
    start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    $display("flush mid-div busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
    check("flush_div_busy", {63'd0, busy}, 64'd0);
    check("flush_div_done", {63'd0, done}, 64'd0);
    check("flush_div_hilo", {hi, lo}, {m_hi, m_lo});

    // Flush coinciding with the multiply write edge suppresses the write
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (MUL_LAT - 1) @(negedge clk);
    check("flush_edge_busy_before", {63'd0, busy}, 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    $display("flush at write edge busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
    check("flush_edge_busy", {63'd0, busy}, 64'd0);
    check("flush_edge_done", {63'd0, done}, 64'd0);
    check("flush_edge_hilo", {hi, lo}, {m_hi, m_lo});

    // Flush with start in IDLE: not accepted
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    $display("flush+mthi in idle hi=%h busy=%b", hi, busy);
    check("flush_idle_hi", {32'd0, hi}, {32'd0, m_hi});
    check("flush_idle_busy", {63'd0, busy}, 64'd0);

`ifdef MDU_MADD_EN
    exec(3'd4, 32'd0, 32'd0);
    exec(3'd5, 32'hFFFF_FFFF, 32'd0);
    exec(3'd7, 32'd1, 32'd1);
    check("maddu_carry", {hi, lo}, {32'd1, 32'd0});
    exec(3'd6, 32'hFFFF_FFFF, 32'd5);
`else
    exec(3'd6, 32'h1111_1111, 32'h2222_2222);
    exec(3'd7, 32'h3333_3333, 32'h4444_4444);
`endif

    // Random ops against the model
    for (int i = 0; i < 14; i++) begin
      logic [2:0]  ro;
      logic [31:0] ra;
      logic [31:0] rb;
      ro = 3'($urandom_range(0, 5));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(8, 31);
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      exec(ro, ra, rb);
    end

    // Reset in the middle of a divide
    @(negedge clk);
    start = 1'b1; op = 3'd2; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    $display("reset mid-div busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
    check("rst_mid_busy", {63'd0, busy}, 64'd0);
    check("rst_mid_done", {63'd0, done}, 64'd0);
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    repeat (40) @(negedge clk);
    check("rst_mid_no_late_write", {hi, lo}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
